nibble_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder built on one shared adder4 instance, processing one nibble per clock, LSB first.
//  A ripple carry register links consecutive nibbles.

---
 rtl/nibble_adder_pkg.sv | 9 +
 rtl/adder4.sv | 10 +
 rtl/nibble_serial_adder.sv | 118 +++++++++++
 tb/tb_nibble_serial_adder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/nibble_adder_pkg.sv
// nibble_adder_pkg: shared state encoding and nibble width for the serial adder.
package nibble_adder_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/adder4.sv
// adder4: combinational 4-bit adder with carry in/out, the shared nibble datapath.
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add, one nibble per clock LSB first through one adder4.
// Define NIBBLE_ADD_OVF_EN to add the registered two's-complement overflow output ovf.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout,
    output logic             busy
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

    state_e state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic carry_q, carry_d, cout_q, cout_d;
    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
    logic nib_cout, accept, run, last;

    assign accept = state_q == ST_IDLE && in_valid;
    assign run = state_q == ST_RUN;
    assign last = idx_q == IW'(NIBBLES - 1);
    assign nib_a = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
    assign nib_b = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];

    adder4 u_adder4 (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        sum_d = sum_q;
        cout_d = cout_q;
        idx_d = idx_q;
        carry_d = carry_q;
        if (accept) begin
            a_d = a;
            b_d = b;
            carry_d = cin;
            idx_d = '0;
            sum_d = '0;
            state_d = ST_RUN;
        end else if (run) begin
            sum_d[NIBBLE_W*int'(idx_q) +: NIBBLE_W] = nib_sum;
            carry_d = nib_cout;
            idx_d = idx_q + 1'b1;
            if (last) begin
                cout_d = nib_cout;
                state_d = ST_DONE;
            end
        end else if (state_q == ST_DONE && out_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
            cout_q <= 1'b0;
            idx_q <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            sum_q <= sum_d;
            cout_q <= cout_d;
            idx_q <= idx_d;
            carry_q <= carry_d;
        end
    end

`ifdef NIBBLE_ADD_OVF_EN
    logic ovf_q, ovf_d;
    // The final nibble's sum MSB is the result MSB, so overflow is known on the last RUN cycle.
    always_comb begin
        ovf_d = accept ? 1'b0
              : (run && last) ? (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[NIBBLE_W-1] != a_q[WIDTH-1])
              : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

    assign in_ready = state_q == ST_IDLE;
    assign out_valid = state_q == ST_DONE;
    assign busy = state_q == ST_RUN || state_q == ST_DONE;
    assign sum = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: randomized and directed checks of the serial adder against integer arithmetic.
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic in_ready, out_valid, cout, busy;
    logic [15:0] sum;
    logic in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic in_ready4, out_valid4, cout4, busy4;
    logic [3:0] sum4;
`ifdef NIBBLE_ADD_OVF_EN
    logic ovf, ovf4;
`endif
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum),
`ifdef NIBBLE_ADD_OVF_EN
        .ovf(ovf),
`endif
        .cout(cout), .busy(busy)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4),
`ifdef NIBBLE_ADD_OVF_EN
        .ovf(ovf4),
`endif
        .cout(cout4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".in_ready"}, 32'(in_ready), 1);
        check({tag, ".sum"}, 32'(sum), 0);
        check({tag, ".cout"}, 32'(cout), 0);
    endtask

    // Reference: plain integer addition; hold cycles stall the consumer with junk on the inputs.
    task automatic op(input logic [15:0] x, input logic [15:0] y, input logic c, input int hold);
        logic [16:0] e;
        int lat;
        e = {1'b0, x} + {1'b0, y} + 17'(c);
        @(negedge clk);
        check("pre.in_ready", 32'(in_ready), 1);
        a = x; b = y; cin = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 4);
        check("sum", 32'(sum), 32'(e[15:0]));
        check("cout", 32'(cout), 32'(e[16]));
        check("busy", 32'(busy), 1);
`ifdef NIBBLE_ADD_OVF_EN
        check("ovf", 32'(ovf), 32'((x[15] == y[15]) && (e[15] != x[15])));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            check("hold.sum", 32'(sum), 32'(e[15:0]));
            check("hold.cout", 32'(cout), 32'(e[16]));
            check("hold.in_ready", 32'(in_ready), 0);
            check("hold.out_valid", 32'(out_valid), 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post.out_valid", 32'(out_valid), 0);
        check("post.in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        logic [4:0] e4;
        int lat;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_idle("reset");
        op(16'h0000, 16'h0000, 1'b0, 0);
        op(16'hFFFF, 16'h0001, 1'b0, 0);
        op(16'h1234, 16'h4321, 1'b1, 0);
        op(16'hABCD, 16'h9876, 1'b1, 5);
        op(16'h7FFF, 16'h0001, 1'b0, 0);
        op(16'h1234, 16'h4321, 1'b0, 0);
        @(negedge clk);
        a = 16'h5555; b = 16'h5555; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        check_idle("midrun");
`ifdef NIBBLE_ADD_OVF_EN
        check("midrun.ovf", 32'(ovf), 0);
`endif
        op(16'h8000, 16'h8000, 1'b0, 0);
        for (int i = 0; i < 30; i++)
            op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        for (int i = 0; i < 6; i++) begin
            logic [3:0] x, y;
            logic c;
            x = (i == 0) ? 4'hF : 4'($urandom);
            y = (i == 0) ? 4'hF : 4'($urandom);
            c = (i == 0) ? 1'b1 : 1'($urandom);
            e4 = {1'b0, x} + {1'b0, y} + 5'(c);
            @(negedge clk);
            a4 = x; b4 = y; cin4 = c; in_valid4 = 1'b1;
            @(posedge clk); #1 in_valid4 = 1'b0;
            lat = 0;
            while (!out_valid4 && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            check("w4.latency", 32'(lat), 1);
            check("w4.sum", 32'(sum4), 32'(e4[3:0]));
            check("w4.cout", 32'(cout4), 32'(e4[4]));
            out_ready4 = 1'b1;
            @(posedge clk); #1 out_ready4 = 1'b0;
            check("w4.in_ready", 32'(in_ready4), 1);
        end
        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
